// File: rtl/hazard_scoreboard.sv
// Decode-stage issue controller: per-register writeback countdowns gate issue of dependent instructions.
// Optional macro HAZARD_SCOREBOARD_FWD_EN enables EX/MEM forwarding (only load-use can stall).
module hazard_scoreboard #(
    parameter int NREGS  = 8,
    parameter int REG_AW = 3,
    parameter int WB_LAT = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [2:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    output logic              stall,
    output logic              bubble,
    output logic              issue,
    output logic [NREGS-1:0]  busy_mask,
    output logic [STAT_W-1:0] stall_count
);

    localparam int CNT_W = $clog2(WB_LAT + 1);
    localparam logic [CNT_W-1:0] LAT = CNT_W'(WB_LAT);

    localparam logic [2:0] OP_LDD = 3'd1;
    localparam logic [2:0] OP_STD = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;

    logic [CNT_W-1:0]  r_cnt [NREGS];
    logic [STAT_W-1:0] r_stall_cnt;
`ifdef HAZARD_SCOREBOARD_FWD_EN
    logic [NREGS-1:0]  r_ld;
`endif

    logic w_use_rs;
    logic w_use_rt;
    logic w_writer;
    logic w_haz_rs;
    logic w_haz_rt;

    always_comb begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        w_writer = 1'b0;
        case (id_opcode)
            OP_LDD: begin w_use_rs = 1'b1;                   w_writer = 1'b1; end
            OP_STD: begin w_use_rs = 1'b1; w_use_rt = 1'b1;                   end
            OP_ADD: begin w_use_rs = 1'b1; w_use_rt = 1'b1; w_writer = 1'b1; end
            OP_NOT: begin w_use_rs = 1'b1;                   w_writer = 1'b1; end
            default: ;
        endcase
    end

`ifdef HAZARD_SCOREBOARD_FWD_EN
    // ALU results are forwarded; a load result is only missing in the cycle right after its issue.
    always_comb begin
        w_haz_rs = w_use_rs && r_ld[id_rs] && (r_cnt[id_rs] > CNT_W'(WB_LAT - 1));
        w_haz_rt = w_use_rt && r_ld[id_rt] && (r_cnt[id_rt] > CNT_W'(WB_LAT - 1));
    end
`else
    // In the last countdown cycle (cnt==1) writeback lands before the read (write-first
    // register file), so that cycle is already safe: dependent issues WB_LAT cycles later.
    always_comb begin
        w_haz_rs = w_use_rs && (r_cnt[id_rs] > CNT_W'(1));
        w_haz_rt = w_use_rt && (r_cnt[id_rt] > CNT_W'(1));
    end
`endif

    assign stall       = id_valid && (w_haz_rs || w_haz_rt);
    assign bubble      = stall;
    assign issue       = id_valid && !stall;
    assign stall_count = r_stall_cnt;

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            busy_mask[r] = (r_cnt[r] != '0);
        end
    end

    // Newest writer to a register replaces any in-flight count (WAW); flush discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                r_cnt[r] <= '0;
            end
`ifdef HAZARD_SCOREBOARD_FWD_EN
            r_ld <= '0;
`endif
        end else if (flush) begin
            for (int r = 0; r < NREGS; r++) begin
                r_cnt[r] <= '0;
            end
`ifdef HAZARD_SCOREBOARD_FWD_EN
            r_ld <= '0;
`endif
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (issue && w_writer && (id_rd == REG_AW'(r))) begin
                    r_cnt[r] <= LAT;
`ifdef HAZARD_SCOREBOARD_FWD_EN
                    r_ld[r]  <= (id_opcode == OP_LDD);
`endif
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - CNT_W'(1);
`ifdef HAZARD_SCOREBOARD_FWD_EN
                    if (r_cnt[r] == CNT_W'(1)) begin
                        r_ld[r] <= 1'b0;
                    end
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (stall && (r_stall_cnt != {STAT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: per-cycle expected stall/issue go through a scoreboard queue.
module tb_hazard_scoreboard;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDD = 3'd1;
    localparam logic [2:0] OP_STD = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_NOT = 3'd4;

`ifdef HAZARD_SCOREBOARD_FWD_EN
    localparam int N_ALU = 0;
    localparam int N_LD  = 1;
`else
    localparam int N_ALU = 3;
    localparam int N_LD  = 3;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       id_valid = 1'b0;
    logic [2:0] id_opcode = '0;
    logic [2:0] id_rs = '0;
    logic [2:0] id_rt = '0;
    logic [2:0] id_rd = '0;
    logic       stall;
    logic       bubble;
    logic       issue;
    logic [7:0] busy_mask;
    logic [3:0] stall_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic stall;
        logic issue;
    } exp_t;
    exp_t q[$];

    hazard_scoreboard #(.NREGS(8), .REG_AW(3), .WB_LAT(4), .STAT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .stall(stall), .bubble(bubble), .issue(issue),
        .busy_mask(busy_mask), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [2:0] rs,
                         input logic [2:0] rt, input logic [2:0] rd, input logic f,
                         input logic exp_stall, input string tag);
        exp_t e;
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        flush     = f;
        q.push_back('{stall: exp_stall, issue: v && !exp_stall});
        @(negedge clk);
        e = q.pop_front();
        check({tag, " stall"},  32'(stall),  32'(e.stall));
        check({tag, " bubble"}, 32'(bubble), 32'(e.stall));
        check({tag, " issue"},  32'(issue),  32'(e.issue));
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic instr(input logic [2:0] op, input logic [2:0] rs, input logic [2:0] rt,
                         input logic [2:0] rd, input int nst, input string tag);
        for (int i = 0; i < nst; i++) drive(1'b1, op, rs, rt, rd, 1'b0, 1'b1, tag);
        drive(1'b1, op, rs, rt, rd, 1'b0, 1'b0, tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, OP_NOP, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, "idle");
    endtask

    task automatic do_reset(input string tag);
        id_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        #1;
        check({tag, " busy_mask"},   32'(busy_mask),   32'h0);
        check({tag, " stall_count"}, 32'(stall_count), 32'h0);
        check({tag, " stall"},       32'(stall),       32'h0);
        check({tag, " issue"},       32'(issue),       32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset("reset0");

        // Back-to-back RAW on an ALU producer
        instr(OP_ADD, 3'd2, 3'd3, 3'd1, 0, "raw producer");
        instr(OP_ADD, 3'd1, 3'd1, 3'd4, N_ALU, "raw consumer");
        check("raw stall_count", 32'(stall_count), 32'(N_ALU));

        // Asynchronous reset in the middle of a countdown (cnt[3]==2)
        instr(OP_ADD, 3'd0, 3'd0, 3'd3, 0, "pre-reset writer");
        idle(2);
        check("pre-reset busy_mask", 32'(busy_mask), 32'h18);
        id_valid = 1'b1; id_opcode = OP_STD; id_rs = 3'd3; id_rt = 3'd0; id_rd = 3'd0;
        #1;
        check("pre-reset stall", 32'(stall), 32'(N_ALU > 0));
        rst_n = 1'b0;
        #1;
        check("async busy_mask",   32'(busy_mask),   32'h0);
        check("async stall_count", 32'(stall_count), 32'h0);
        check("async stall",       32'(stall),       32'h0);
        check("async bubble",      32'(bubble),      32'h0);
        id_valid = 1'b0;
        #1;
        check("async issue", 32'(issue), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load-use
        do_reset("reset1");
        instr(OP_LDD, 3'd0, 3'd0, 3'd1, 0, "load producer");
        instr(OP_ADD, 3'd1, 3'd2, 3'd4, N_LD, "load consumer");
        check("load stall_count", 32'(stall_count), 32'(N_LD));
        idle(4);
        check("drained busy_mask", 32'(busy_mask), 32'h0);

        // Flush while r1/r2 busy and ADD r7 issuing
        instr(OP_ADD, 3'd0, 3'd0, 3'd1, 0, "flush setup r1");
        instr(OP_ADD, 3'd0, 3'd0, 3'd2, 0, "flush setup r2");
        check("pre-flush busy_mask", 32'(busy_mask), 32'h06);
        drive(1'b1, OP_ADD, 3'd0, 3'd0, 3'd7, 1'b1, 1'b0, "flush issue");
        check("post-flush busy_mask",   32'(busy_mask),   32'h0);
        check("post-flush stall_count", 32'(stall_count), 32'(N_LD));
        instr(OP_ADD, 3'd1, 3'd2, 3'd5, 0, "post-flush consumer");
        idle(4);

        // WAW: second writer's count governs the consumer
        do_reset("reset2");
        instr(OP_ADD, 3'd0, 3'd0, 3'd5, 0, "waw first");
        check("waw busy_mask", 32'(busy_mask), 32'h20);
        instr(OP_NOT, 3'd6, 3'd0, 3'd5, 0, "waw second");
        instr(OP_STD, 3'd5, 3'd0, 3'd7, N_ALU, "waw store");
        check("store not writer", 32'(busy_mask[7]), 32'h0);

        // Saturating stall counter, then non-users of sources
        do_reset("reset3");
        for (int i = 0; i < 20; i++) begin
            instr(OP_LDD, 3'd0, 3'd0, 3'd1, 0, "sat load");
            instr(OP_ADD, 3'd1, 3'd0, 3'd2, N_LD, "sat consumer");
            if (i == 0) check("sat first stall_count", 32'(stall_count), 32'(N_LD));
        end
        check("sat stall_count", 32'(stall_count), 32'hF);
        check("r2 busy", 32'(busy_mask[2]), 32'h1);
        drive(1'b1, OP_NOP, 3'd2, 3'd2, 3'd5, 1'b0, 1'b0, "nop busy src");
        drive(1'b1, 3'd6,   3'd2, 3'd2, 3'd5, 1'b0, 1'b0, "op6 busy src");
        check("op6 not writer", 32'(busy_mask[5]), 32'h0);
        check("sat hold stall_count", 32'(stall_count), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
